// File: rtl/wb_bank_arbiter_pkg.sv
// Package wb_itf: Wishbone request/response structs, bus widths and the
// arbitration enums shared by wb_bank_arbiter and wb_bank_grant.
package wb_itf;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int SEL_WIDTH  = DATA_WIDTH / 8;

   typedef struct packed {
      logic                  cyc;
      logic                  stb;
      logic                  we;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
      logic [SEL_WIDTH-1:0]  sel;
   } wb_input_t;

   typedef struct packed {
      logic                  ack;
      logic                  stall;
      logic [DATA_WIDTH-1:0] data;
   } wb_output_t;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_id_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } bank_owner_e;

   // Byte mask seen by the RAM: reads never write, so they get an empty mask.
   function automatic logic [SEL_WIDTH-1:0] write_mask(input logic we,
                                                       input logic [SEL_WIDTH-1:0] sel);
      return we ? sel : '0;
   endfunction

endpackage

// File: rtl/wb_bank_grant.sv
// wb_bank_grant: per-bank arbiter between ports A and B.
// Holds the bank's round-robin priority bit (PORT_A preferred after reset).
// With WB_ARB_LOCK_EN defined, a granted port also keeps the bank while its
// cyc stays high, for up to LOCK_MAX accepted transfers.
// Grants are combinational and are forced low while wb_reset_n is low, so a
// grant is exactly an accepted transfer at the next rising edge.
module wb_bank_grant
   import wb_itf::*;
`ifdef WB_ARB_LOCK_EN
#(
   parameter int LOCK_MAX = 16
)
`endif
(
   input  logic wb_clk,
   input  logic wb_reset_n,
`ifdef WB_ARB_LOCK_EN
   input  logic cyc_a,
   input  logic cyc_b,
`endif
   input  logic req_a,
   input  logic req_b,
   output logic grant_a,
   output logic grant_b
);

   port_id_e prio_reg, prio_next;

`ifdef WB_ARB_LOCK_EN
   // Counter holds transfers already taken inside the lock (1..LOCK_MAX-1).
   localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

   bank_owner_e      state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   port_id_e         arb_prio;

   // Lock owner streams its transfers; otherwise round-robin per transfer.
   always_comb begin
      grant_a    = 1'b0;
      grant_b    = 1'b0;
      prio_next  = prio_reg;
      state_next = state_reg;
      cnt_next   = cnt_reg;
      arb_prio   = prio_reg;
      if (wb_reset_n) begin
         if (state_reg == OWN_A && cyc_a) begin
            grant_a = req_a;
            if (req_a) begin
               if (cnt_reg == CNT_W'(LOCK_MAX - 1)) begin
                  state_next = IDLE;
                  cnt_next   = '0;
                  prio_next  = PORT_B;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end else if (state_reg == OWN_B && cyc_b) begin
            grant_b = req_b;
            if (req_b) begin
               if (cnt_reg == CNT_W'(LOCK_MAX - 1)) begin
                  state_next = IDLE;
                  cnt_next   = '0;
                  prio_next  = PORT_A;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end else begin
            // An owner that dropped cyc hands priority to the other side in this same cycle.
            if (state_reg == OWN_A) begin
               arb_prio = PORT_B;
            end else if (state_reg == OWN_B) begin
               arb_prio = PORT_A;
            end
            state_next = IDLE;
            cnt_next   = '0;
            prio_next  = arb_prio;
            if (req_a && req_b) begin
               grant_a   = (arb_prio == PORT_A);
               grant_b   = !grant_a;
               prio_next = grant_a ? PORT_B : PORT_A;
            end else begin
               grant_a = req_a;
               grant_b = req_b;
            end
            if (LOCK_MAX == 1) begin
               if (grant_a) begin
                  prio_next = PORT_B;
               end else if (grant_b) begin
                  prio_next = PORT_A;
               end
            end else if (grant_a) begin
               state_next = OWN_A;
               cnt_next   = CNT_W'(1);
            end else if (grant_b) begin
               state_next = OWN_B;
               cnt_next   = CNT_W'(1);
            end
         end
      end
   end

   // Lock ownership state and transfer count.
   always_ff @(posedge wb_clk) begin
      if (!wb_reset_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end
`else
   // Per-transfer round-robin: a resolved collision hands the next one to the loser.
   always_comb begin
      grant_a   = 1'b0;
      grant_b   = 1'b0;
      prio_next = prio_reg;
      if (wb_reset_n) begin
         if (req_a && req_b) begin
            grant_a   = (prio_reg == PORT_A);
            grant_b   = !grant_a;
            prio_next = grant_a ? PORT_B : PORT_A;
         end else begin
            grant_a = req_a;
            grant_b = req_b;
         end
      end
   end
`endif

   // Priority bit register.
   always_ff @(posedge wb_clk) begin
      if (!wb_reset_n) begin
         prio_reg <= PORT_A;
      end else begin
         prio_reg <= prio_next;
      end
   end

endmodule

// File: rtl/wb_bank_arbiter.sv
// wb_bank_arbiter: two pipelined Wishbone slave ports sharing two
// single-port SRAM banks. The bank is addr[BANK_BIT], the word index is
// addr[WORD_AW+1:2]. Ports on different banks run in parallel; same-bank
// collisions are resolved by one wb_bank_grant per bank, the loser stalls.
// Ack is registered, one cycle after acceptance; read data is taken from the
// bank that served the transfer while ack is high.
// Optional feature macro: WB_ARB_LOCK_EN (bus-locked bank ownership, LOCK_MAX).
module wb_bank_arbiter
   import wb_itf::*;
#(
   parameter int WORD_AW  = 8,
   parameter int BANK_BIT = 10
`ifdef WB_ARB_LOCK_EN
   ,
   parameter int LOCK_MAX = 16
`endif
) (
   input  logic                             wb_clk,
   input  logic                             wb_reset_n,
   input  wb_input_t                        pA_wb_i,
   output wb_output_t                       pA_wb_o,
   input  wb_input_t                        pB_wb_i,
   output wb_output_t                       pB_wb_o,
   output logic [1:0]                       bank_en,
   output logic [1:0]                       bank_we,
   output logic [1:0][WORD_AW-1:0]          bank_addr,
   output logic [1:0][DATA_WIDTH-1:0]       bank_wdata,
   output logic [1:0][SEL_WIDTH-1:0]        bank_wmask,
   input  logic [1:0][DATA_WIDTH-1:0]       bank_rdata
);

   logic       req_a, req_b;
   logic       bank_a, bank_b;
   logic [1:0] grant_a, grant_b;
   logic       acc_a, acc_b;
   logic       ack_a_reg, ack_b_reg;
   logic       rd_bank_a_reg, rd_bank_b_reg;
   logic       unused_addr;

   assign req_a  = pA_wb_i.cyc & pA_wb_i.stb;
   assign req_b  = pB_wb_i.cyc & pB_wb_i.stb;
   assign bank_a = pA_wb_i.addr[BANK_BIT];
   assign bank_b = pB_wb_i.addr[BANK_BIT];
   assign acc_a  = |grant_a;
   assign acc_b  = |grant_b;

   // Byte-lane bits and bits above the bank select take no part in decoding.
   assign unused_addr = ^{pA_wb_i.addr, pB_wb_i.addr};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_bank
         logic use_b;

         wb_bank_grant
`ifdef WB_ARB_LOCK_EN
            #(.LOCK_MAX(LOCK_MAX))
`endif
            u_grant (
               .wb_clk     (wb_clk),
               .wb_reset_n (wb_reset_n),
`ifdef WB_ARB_LOCK_EN
               .cyc_a      (pA_wb_i.cyc),
               .cyc_b      (pB_wb_i.cyc),
`endif
               .req_a      (req_a & (bank_a == 1'(gi))),
               .req_b      (req_b & (bank_b == 1'(gi))),
               .grant_a    (grant_a[gi]),
               .grant_b    (grant_b[gi])
            );

         // The bank follows whichever port won it; an idle bank gets no strobe and no mask.
         assign use_b          = grant_b[gi];
         assign bank_en[gi]    = grant_a[gi] | grant_b[gi];
         assign bank_we[gi]    = use_b ? pB_wb_i.we : (grant_a[gi] & pA_wb_i.we);
         assign bank_addr[gi]  = use_b ? pB_wb_i.addr[WORD_AW+1:2] : pA_wb_i.addr[WORD_AW+1:2];
         assign bank_wdata[gi] = use_b ? pB_wb_i.data : pA_wb_i.data;
         assign bank_wmask[gi] = use_b ? write_mask(pB_wb_i.we, pB_wb_i.sel)
                                       : write_mask(grant_a[gi] & pA_wb_i.we, pA_wb_i.sel);
      end
   endgenerate

   // Ack one cycle after acceptance; remember which bank returns the read data.
   always_ff @(posedge wb_clk) begin
      if (!wb_reset_n) begin
         ack_a_reg     <= 1'b0;
         ack_b_reg     <= 1'b0;
         rd_bank_a_reg <= 1'b0;
         rd_bank_b_reg <= 1'b0;
      end else begin
         ack_a_reg <= acc_a;
         ack_b_reg <= acc_b;
         if (acc_a) begin
            rd_bank_a_reg <= bank_a;
         end
         if (acc_b) begin
            rd_bank_b_reg <= bank_b;
         end
      end
   end

   // Port responses: stall held high through reset, data only during ack.
   always_comb begin
      pA_wb_o.ack   = ack_a_reg;
      pA_wb_o.stall = !wb_reset_n | (req_a & !acc_a);
      pA_wb_o.data  = ack_a_reg ? bank_rdata[rd_bank_a_reg] : '0;
      pB_wb_o.ack   = ack_b_reg;
      pB_wb_o.stall = !wb_reset_n | (req_b & !acc_b);
      pB_wb_o.data  = ack_b_reg ? bank_rdata[rd_bank_b_reg] : '0;
   end

endmodule

// File: tb/tb_wb_bank_arbiter.sv
// tb_wb_bank_arbiter: directed scenarios plus randomized traffic on both
// ports. A reference model (per-bank priority bits, shadow memory updated in
// acceptance order) predicts stalls and pushes expected responses into
// per-port queues; a monitor pops and compares on every ack.
module tb_wb_bank_arbiter;
   import wb_itf::*;

   localparam int WORD_AW  = 8;
   localparam int BANK_BIT = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                        reset_n;
   wb_input_t                   a_i, b_i;
   wb_output_t                  a_o, b_o;
   logic [1:0]                  bank_en, bank_we;
   logic [1:0][WORD_AW-1:0]     bank_addr;
   logic [1:0][DATA_WIDTH-1:0]  bank_wdata;
   logic [1:0][SEL_WIDTH-1:0]   bank_wmask;
   logic [1:0][DATA_WIDTH-1:0]  bank_rdata;

   wb_bank_arbiter #(.WORD_AW(WORD_AW), .BANK_BIT(BANK_BIT)) dut (
      .wb_clk     (clk),
      .wb_reset_n (reset_n),
      .pA_wb_i    (a_i),
      .pA_wb_o    (a_o),
      .pB_wb_i    (b_i),
      .pB_wb_o    (b_o),
      .bank_en    (bank_en),
      .bank_we    (bank_we),
      .bank_addr  (bank_addr),
      .bank_wdata (bank_wdata),
      .bank_wmask (bank_wmask),
      .bank_rdata (bank_rdata)
   );

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] mask);
      logic [31:0] r;
      r = old_w;
      for (int k = 0; k < 4; k++) if (mask[k]) r[8*k +: 8] = new_w[8*k +: 8];
      return r;
   endfunction

   // Single-port SRAM banks with one-cycle registered read.
   for (genvar gi = 0; gi < 2; gi++) begin : g_ram
      logic [31:0] mem [256];
      initial for (int i = 0; i < 256; i++) mem[i] = '0;
      always @(posedge clk) begin
         if (bank_en[gi]) begin
            if (bank_we[gi]) mem[bank_addr[gi]] <= merge(mem[bank_addr[gi]], bank_wdata[gi], bank_wmask[gi]);
            else bank_rdata[gi] <= mem[bank_addr[gi]];
         end
      end
   end

   // ---------------- reference model and scoreboard ----------------
   typedef struct {
      bit          is_read;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q [2][$];
   logic [31:0] shadow [2][256];
   bit   [1:0]  prio_m;      // per bank: 1 = B preferred on the next collision
   bit          last_acc_a, last_acc_b;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h required %h", nm, act, req);
      end
   endtask

   task automatic accept(input int p, input wb_input_t t);
      exp_t e;
      int   bk, idx;
      bk  = int'(t.addr[BANK_BIT]);
      idx = int'(t.addr[WORD_AW+1:2]);
      e.is_read = !t.we;
      e.data    = '0;
      if (t.we) shadow[bk][idx] = merge(shadow[bk][idx], t.data, t.sel);
      else e.data = shadow[bk][idx];
      exp_q[p].push_back(e);
   endtask

   // Called at a negedge: predict grants, check stalls, then commit at the edge.
   task automatic step_edge();
      bit ra, rb, ba, bb, ga, gb, coll;
      ra = a_i.cyc && a_i.stb;
      rb = b_i.cyc && b_i.stb;
      ba = a_i.addr[BANK_BIT];
      bb = b_i.addr[BANK_BIT];
      coll = ra && rb && (ba == bb);
      ga = 1'b0;
      gb = 1'b0;
      if (reset_n) begin
         if (coll) begin
            if (prio_m[ba]) gb = 1'b1;
            else ga = 1'b1;
         end else begin
            ga = ra;
            gb = rb;
         end
      end
      chk("stall_A", 32'(a_o.stall), 32'(!reset_n || (ra && !ga)));
      chk("stall_B", 32'(b_o.stall), 32'(!reset_n || (rb && !gb)));
      @(posedge clk);
      if (!reset_n) begin
         prio_m = 2'b00;
      end else begin
         if (coll) prio_m[ba] = ga;
         if (ga) accept(0, a_i);
         if (gb) accept(1, b_i);
      end
      last_acc_a = ga;
      last_acc_b = gb;
      #1;
   endtask

   task automatic tick();
      @(negedge clk);
      step_edge();
   endtask

   // Monitor: every negedge, compare each port's ack/data with the queue.
   task automatic check_resp(input int p, input wb_output_t o);
      exp_t  e;
      string nm;
      nm = (p == 0) ? "A" : "B";
      n_checks++;
      if (o.ack) begin
         if (exp_q[p].size() == 0) begin
            n_errors++;
            $display("FAIL ack_%s spurious: got ack=1 required 0", nm);
         end else begin
            e = exp_q[p].pop_front();
            if (e.is_read) begin
               n_checks++;
               if (o.data !== e.data) begin
                  n_errors++;
                  $display("FAIL rdata_%s: got %h required %h", nm, o.data, e.data);
               end
            end
            $display("txn port %s %s data=%h", nm, e.is_read ? "rd" : "wr", o.data);
         end
      end else begin
         if (exp_q[p].size() != 0) begin
            n_errors++;
            void'(exp_q[p].pop_front());
            $display("FAIL ack_%s missing: got ack=0 required 1", nm);
         end
         n_checks++;
         if (o.data !== '0) begin
            n_errors++;
            $display("FAIL idle_data_%s: got %h required 0", nm, o.data);
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         check_resp(0, a_o);
         check_resp(1, b_o);
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic wb_input_t wr(input logic [31:0] addr, input logic [31:0] data,
                                    input logic [3:0] sel);
      wb_input_t t;
      t = '0;
      t.cyc = 1'b1; t.stb = 1'b1; t.we = 1'b1;
      t.addr = addr; t.data = data; t.sel = sel;
      return t;
   endfunction

   function automatic wb_input_t rd(input logic [31:0] addr);
      wb_input_t t;
      t = '0;
      t.cyc = 1'b1; t.stb = 1'b1; t.we = 1'b0;
      t.addr = addr; t.data = $urandom; t.sel = 4'hF;
      return t;
   endfunction

   function automatic wb_input_t rand_txn();
      wb_input_t t;
      t = '0;
      if ($urandom_range(0, 99) < 65) begin
         t.cyc  = 1'b1;
         t.stb  = 1'b1;
         t.we   = 1'($urandom_range(0, 1));
         t.addr = (32'($urandom_range(0, 1)) << 12) | (32'($urandom_range(0, 1)) << BANK_BIT)
                | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
         t.data = $urandom;
         t.sel  = 4'($urandom_range(0, 15));
      end else begin
         t.cyc = 1'($urandom_range(0, 1));
      end
      return t;
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      for (int b = 0; b < 2; b++) for (int i = 0; i < 256; i++) shadow[b][i] = '0;
      prio_m     = 2'b00;
      last_acc_a = 1'b0;
      last_acc_b = 1'b0;
      reset_n    = 1'b0;
      a_i        = '0;
      b_i        = '0;
      repeat (3) tick();
      reset_n = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_ack_A", 32'(a_o.ack), 0);
      chk("rst_ack_B", 32'(b_o.ack), 0);
      chk("rst_bank_en", 32'(bank_en), 0);
      step_edge();

      // 1: single write to bank0 word 1
      a_i = wr(32'h004, 32'hCAFEBABE, 4'hF);
      @(negedge clk);
      chk("t1_bank_en0", 32'(bank_en[0]), 1);
      chk("t1_bank_en1", 32'(bank_en[1]), 0);
      chk("t1_bank_addr0", 32'(bank_addr[0]), 1);
      chk("t1_bank_wmask0", 32'(bank_wmask[0]), 32'hF);
      step_edge();
      a_i = '0;
      @(negedge clk);
      chk("t1_ack_A", 32'(a_o.ack), 1);
      step_edge();

      // 2: bank0 collision, A wins first, B wins the next one
      a_i = wr(32'h004, 32'h11110000, 4'hF);
      b_i = wr(32'h008, 32'h22220000, 4'hF);
      @(negedge clk);
      chk("t2_stall_A", 32'(a_o.stall), 0);
      chk("t2_stall_B", 32'(b_o.stall), 1);
      step_edge();
      a_i = '0;
      @(negedge clk);
      chk("t2_stall_B_next", 32'(b_o.stall), 0);
      step_edge();
      a_i = wr(32'h00C, 32'h33330000, 4'hF);
      b_i = wr(32'h010, 32'h44440000, 4'hF);
      @(negedge clk);
      chk("t2_coll2_stall_A", 32'(a_o.stall), 1);
      chk("t2_coll2_stall_B", 32'(b_o.stall), 0);
      step_edge();
      b_i = '0;
      tick();
      a_i = '0;
      tick();

      // 3: different banks in parallel
      a_i = wr(32'h004, 32'h55555555, 4'hF);
      b_i = wr(32'h404, 32'h66666666, 4'hF);
      @(negedge clk);
      chk("t3_stall_A", 32'(a_o.stall), 0);
      chk("t3_stall_B", 32'(b_o.stall), 0);
      step_edge();
      a_i = '0;
      b_i = '0;
      @(negedge clk);
      chk("t3_ack_A", 32'(a_o.ack), 1);
      chk("t3_ack_B", 32'(b_o.ack), 1);
      step_edge();

      // 4: byte-masked write merge, back-to-back
      a_i = wr(32'h020, 32'hFFFFFFFF, 4'hF);
      tick();
      a_i = wr(32'h020, 32'h01020304, 4'b0101);
      tick();
      a_i = rd(32'h020);
      tick();
      a_i = '0;
      @(negedge clk);
      chk("t4_ack_A", 32'(a_o.ack), 1);
      chk("t4_rdata", a_o.data, 32'hFF02FF04);
      step_edge();

      // 5: reset during an ack cycle, with a new request held across reset
      a_i = wr(32'h030, 32'h77777777, 4'hF);
      tick();
      a_i = wr(32'h034, 32'h88888888, 4'hF);
      @(negedge clk);
      chk("t5_ack_before", 32'(a_o.ack), 1);
      reset_n = 1'b0;
      #1;
      step_edge();
      @(negedge clk);
      chk("t5_ack_dropped", 32'(a_o.ack), 0);
      chk("t5_stall_A", 32'(a_o.stall), 1);
      chk("t5_stall_B", 32'(b_o.stall), 1);
      chk("t5_bank_en", 32'(bank_en), 0);
      step_edge();
      reset_n = 1'b1;
      tick();
      a_i = rd(32'h034);
      tick();
      a_i = '0;
      tick();

      // Randomized traffic on both ports
      for (int c = 0; c < 600; c++) begin
         if (last_acc_a || !(a_i.cyc && a_i.stb)) a_i = rand_txn();
         if (last_acc_b || !(b_i.cyc && b_i.stb)) b_i = rand_txn();
         tick();
      end
      a_i = '0;
      b_i = '0;
      repeat (2) tick();
      chk("drain_A", 32'(exp_q[0].size()), 0);
      chk("drain_B", 32'(exp_q[1].size()), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
